// File: rtl/horner_synth_div.sv
// ============================================================================
// Module   : horner_synth_div
// Purpose  : Synthetic division of P(x) by (x - r); streams quotient then remainder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module horner_synth_div #(
    parameter int W  = 32,
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [W-1:0]  root,
    input  logic [DW-1:0] degree,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_coef,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic          out_last,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCEPT = 3'd1,
        S_MUL    = 3'd2,
        S_ADD    = 3'd3,
        S_EMIT   = 3'd4
    } state_t;

    state_t        r_state;
    logic [W-1:0]  r_root;
    logic [W-1:0]  r_coef;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_prod;
    logic [DW-1:0] r_count;
    logic [W-1:0]  r_out_data;
    logic          r_out_valid;
    logic          r_out_last;
    logic          r_busy;
    logic          r_done;

    logic [W-1:0]  w_prod;
    logic [W-1:0]  w_sum;
    logic          w_in_fire;
    logic          w_out_fire;
    logic          w_last_beat;

    // Both operands are W bits, so the product is naturally truncated to the low W bits.
    assign w_prod      = r_root * r_b;
    assign w_sum       = r_coef + r_prod;
    assign w_in_fire   = in_valid & in_ready;
    assign w_out_fire  = r_out_valid & out_ready;
    assign w_last_beat = (r_count == '0);

    assign in_ready  = (r_state == S_ACCEPT);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign busy      = r_busy;
    assign done      = r_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_root      <= '0;
            r_coef      <= '0;
            r_b         <= '0;
            r_prod      <= '0;
            r_count     <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_root  <= root;
                        r_count <= degree;
                        r_b     <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_ACCEPT;
                    end
                end
                S_ACCEPT: begin
                    if (w_in_fire) begin
                        r_coef  <= in_coef;
                        r_state <= S_MUL;
                    end
                end
                S_MUL: begin
                    r_prod  <= w_prod;
                    r_state <= S_ADD;
                end
                S_ADD: begin
                    // Output beat is registered here so it is stable for the whole EMIT stall.
                    r_b         <= w_sum;
                    r_out_data  <= w_sum;
                    r_out_valid <= 1'b1;
                    r_out_last  <= w_last_beat;
                    r_state     <= S_EMIT;
                end
                S_EMIT: begin
                    if (w_out_fire) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        r_out_data  <= '0;
                        if (w_last_beat) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_count <= r_count - DW'(1);
                            r_state <= S_ACCEPT;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/horner_synth_div.md
Name: horner_synth_div

Overview:
- Sequential synthetic-division (Horner deflation) engine. It divides P(x) = a_N x^N + ... + a_0 by (x - r).
- It streams out the quotient coefficients q_{N-1}..q_0, followed by the remainder P(r).
- It is the inverse-direction companion of the pipelined multiply-add Horner evaluator, and reuses the same registered-multiply then registered-add datapath style.
- It sits between a coefficient source and a coefficient sink, with valid/ready on both sides.

Parameters:
- W, 32, datapath width of coefficients, root and results.
- DW, 4, width of the degree field; maximum degree is 2^DW - 1.

Ports:
- clk  input  1  clock, rising-edge.
- reset  input  1  synchronous, active-high.
- start  input  1  pulse; latches root and degree when idle.
- root  input  W  divisor root r.
- degree  input  DW  polynomial degree N.
- in_valid  input  1  coefficient source valid.
- in_ready  output  1  engine accepts a coefficient.
- in_coef  input  W  coefficient, highest order first (a_N first).
- out_valid  output  1  result valid.
- out_ready  input  1  sink accepts a result.
- out_data  output  W  quotient coefficient or remainder.
- out_last  output  1  qualifies out_data as the remainder (final beat).
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the remainder handshake.

Behaviour:
- Reset is synchronous, active-high, clock clk.
- On reset:
  - state=IDLE; in_ready, out_valid, out_last, busy and done = 0.
  - out_data = 0; internal acc b = 0, prod = 0, count = 0.
  - Reset asserted mid-operation aborts immediately. No partial output is completed.
- States: IDLE, ACCEPT, MUL, ADD, EMIT.
- IDLE:
  - start=1 latches r and N, sets count=N, clears b=0, and moves to ACCEPT.
  - start is ignored in every other state.
- ACCEPT:
  - in_ready=1 combinationally in this state only.
  - On in_valid&in_ready: latch coef and move to MUL.
- MUL: prod <= low W bits of r*b; move to ADD.
- ADD: b <= (coef + prod) mod 2^W; move to EMIT.
- EMIT:
  - out_valid=1 and out_data=b.
  - out_last=1 when count==0.
  - out_data and out_last hold stable while out_ready=0.
  - On out_valid&out_ready with count!=0: count decrements and the state returns to ACCEPT.
  - On out_valid&out_ready with count==0: done pulses on the next cycle and the state goes to IDLE.
- Recurrence: b_N = a_N, b_k = a_k + r*b_{k+1}. Emitted beats are b_N..b_0, which are q_{N-1}..q_0 followed by remainder b_0.
- Total beats = N+1. Degree 0 emits a single beat, a_0, with out_last=1.
- Arithmetic is two's-complement/unsigned agnostic: truncate to W bits, no saturation, no overflow flag.
- Latency: coefficient handshake in cycle c gives out_valid in cycle c+3.
  - Minimum throughput is one coefficient per 4 cycles (ACCEPT, MUL, ADD, EMIT).
  - in_ready is never high while out_valid is high.
- A coefficient presented outside ACCEPT is not consumed. The source must hold it until in_ready.
- busy is high from the cycle after start through EMIT of the last beat. done and busy are never both high.
- When start and reset are both high, reset wins.

Test Plan:
- N=2, r=1, coefs 1, 0xFFFFFFFD, 2 (x^2-3x+2) -> beats 0x1, 0xFFFFFFFE, 0x0; out_last only on the third beat; done pulses once.
- N=1, r=9, coefs 0xA, 0x1 -> beats 0xA then 0x5B (remainder 91, out_last=1); first out_valid exactly 3 cycles after the a_1 handshake.
- N=0, r=7, coef 5 -> single beat 0x5 with out_last=1. Holding start high during busy causes no restart.
- Backpressure: the N=2 case with out_ready low for 5 cycles on each beat -> out_data/out_last stable, in_ready stays 0, results unchanged; in_valid gaps of 3 cycles also give unchanged results.
- Overflow: N=1, r=2, coefs 0x80000000, 0x1 -> beats 0x80000000, 0x00000001 (product truncated).
- Reset mid-op: assert reset during the MUL state of the second coefficient -> next cycle all outputs 0 and busy=0; a new start then runs the N=1, r=9 case correctly.
